cmp_stream_tracker: RTL
=======================

# cmp_stream_tracker

Streaming consumer that sits directly downstream of the 4-bit magnitude comparator. The comparator compares each incoming sample (A) against a threshold (B) and produces Eq/Gt/Sm. This block registers those flags together with the sample, and keeps the following statistics:
- running max and min of the samples;
- saturating per-outcome counts;
- a hysteretic over-threshold alarm, raised after RUN_LEN consecutive Gt samples.

It also flags illegal flag combinations from the comparator.

## Interface
Parameters:
- CNT_W, default 8: width of each outcome counter.
- RUN_LEN, default 3: consecutive Gt samples needed to raise alarm. Legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear. Same effect as rst on all state, including err.
- in_valid  input  1  sample qualifier; eq/gt/sm/in_data are sampled only when high.
- in_data  input  4  sample value; the same value driven on the comparator's A.
- eq, gt, sm  input  1 each  comparator outputs for in_data vs. the threshold.
- max_val  output  4  largest accepted sample since reset/clear.
- min_val  output  4  smallest accepted sample since reset/clear.
- gt_cnt, eq_cnt, sm_cnt  output  CNT_W each  accepted-sample counts per outcome.
- alarm  output  1  over-threshold alarm.
- out_valid  output  1  one-cycle pulse: statistics just updated.
- err  output  1  sticky: a non-one-hot flag set was received.

## Operation
- Accepted sample: in_valid=1, clear=0, and {eq,gt,sm} exactly one-hot.
- Rejected sample: in_valid=1, clear=0, flags not one-hot (000, 011, 111, ...).
  - Dropped entirely: no counter, max/min, run or state change; no out_valid.
  - err is set and stays set until rst or clear.
- Max/min update on each accepted sample:
  - max_val <= max(max_val, in_data); min_val <= min(min_val, in_data).
  - The first accepted sample after reset/clear loads both directly.
- Counters:
  - Increment the counter matching the one-hot flag.
  - Saturate at 2^CNT_W-1; never wrap.
- Run counter (internal, 4 bits):
  - Increments on a gt sample, saturating at RUN_LEN.
  - Cleared on an eq or sm sample.
- State machine, states IDLE / TRACK / ALARM:
  - IDLE: no accepted sample since reset/clear. An accepted sample moves to TRACK, or to ALARM if that sample completes the run (RUN_LEN=1 and gt).
  - TRACK: moves to ALARM on the accepted gt sample that brings the run count to RUN_LEN.
  - ALARM: eq and gt samples hold ALARM. A sm sample moves to TRACK with run=0 (hysteresis: only falling strictly below the threshold clears the alarm).
  - alarm = (state == ALARM), registered.
- clear or rst in any state: return to IDLE with all state reset, including mid-run and during ALARM.

## Timing
- Reset/clear values:
  - max_val=0, min_val=0 (held until the first sample loads them).
  - All counts 0.
  - alarm=0, out_valid=0, err=0, state IDLE, run=0.
- Latency: one cycle. An accepted sample at edge N is reflected on every output after edge N; out_valid is high for exactly that cycle.
- Back-to-back samples are accepted every cycle with no bubble. No backpressure.
- Simultaneous clear and in_valid: clear wins, the sample is discarded, out_valid=0.
- rst has priority over clear.
- alarm rises in the cycle after the RUN_LEN-th consecutive gt sample. It falls in the cycle after the first sm sample.
- in_valid=0 cycles do not break a run; only an eq or sm sample does.

## Test plan
- Reset, then samples 5(gt),2(sm),9(gt),7(eq) with one-hot flags -> after the last sample: max=9, min=2, gt_cnt=2, sm_cnt=1, eq_cnt=1, alarm=0, one out_valid pulse per sample.
- RUN_LEN=3: gt,gt,idle cycle,gt -> alarm=1 the cycle after the third gt. Then eq -> alarm stays 1. Then sm -> alarm=0 the next cycle, run restarts: two gt samples leave alarm=0.
- Flags 011 with in_valid=1 -> err=1, out_valid=0, counts/max/min unchanged. A subsequent legal sample is accepted normally; err stays 1 until clear.
- CNT_W=2: five consecutive eq samples -> eq_cnt=3 (saturated, no wrap).
- clear asserted during ALARM, with in_valid=1 and gt the same cycle -> next cycle all outputs at reset values, state IDLE, sample not counted.
- RUN_LEN=1: first sample after reset is gt -> IDLE to ALARM directly; alarm=1 and max=min=sample value one cycle later.

Source files
------------

// File: rtl/cmp_stream_tracker.sv
`default_nettype none
// ============================================================================
// Module   : cmp_stream_tracker
// Purpose  : Streaming consumer placed after a 4-bit magnitude comparator.
//            Registers each qualified sample with its Eq/Gt/Sm flags and
//            keeps running max/min, saturating per-outcome counts, a
//            hysteretic over-threshold alarm and a sticky illegal-flag error.
// Ports    : clk, rst (sync, active-high), clear (sync soft clear)
//            in_valid, in_data[3:0], eq, gt, sm       -- sample + flags
//            max_val[3:0], min_val[3:0]               -- running extremes
//            gt_cnt, eq_cnt, sm_cnt [CNT_W-1:0]       -- outcome counts
//            alarm, out_valid, err                    -- status
// Revision : 1.0 - initial release
// ============================================================================
module cmp_stream_tracker #(
   parameter int CNT_W   = 8,
   parameter int RUN_LEN = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [3:0]       in_data,
   input  logic             eq,
   input  logic             gt,
   input  logic             sm,
   output logic [3:0]       max_val,
   output logic [3:0]       min_val,
   output logic [CNT_W-1:0] gt_cnt,
   output logic [CNT_W-1:0] eq_cnt,
   output logic [CNT_W-1:0] sm_cnt,
   output logic             alarm,
   output logic             out_valid,
   output logic             err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_TRACK = 2'd1,
      S_ALARM = 2'd2
   } state_t;

   localparam logic [3:0]       C_RUN_LEN = 4'(RUN_LEN);
   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [3:0]       run_q, run_d;
   logic [3:0]       max_q, max_d;
   logic [3:0]       min_q, min_d;
   logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
   logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
   logic [CNT_W-1:0] sm_cnt_q, sm_cnt_d;
   logic             valid_q, valid_d;
   logic             alarm_q, alarm_d;
   logic             err_q, err_d;

   logic w_onehot;
   logic w_accept;
   logic w_reject;

   assign w_onehot = (eq & ~gt & ~sm) | (~eq & gt & ~sm) | (~eq & ~gt & sm);
   assign w_accept = in_valid & ~clear & w_onehot;
   assign w_reject = in_valid & ~clear & ~w_onehot;

   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      max_d    = max_q;
      min_d    = min_q;
      gt_cnt_d = gt_cnt_q;
      eq_cnt_d = eq_cnt_q;
      sm_cnt_d = sm_cnt_q;
      valid_d  = 1'b0;
      err_d    = err_q;

      if (clear) begin
         state_d  = S_IDLE;
         run_d    = 4'd0;
         max_d    = 4'd0;
         min_d    = 4'd0;
         gt_cnt_d = '0;
         eq_cnt_d = '0;
         sm_cnt_d = '0;
         err_d    = 1'b0;
      end else begin
         if (w_reject) begin
            err_d = 1'b1;
         end
         if (w_accept) begin
            valid_d = 1'b1;

            // IDLE means nothing accepted yet, so the first sample loads
            // both extremes regardless of the zeroed reset values.
            if (state_q == S_IDLE) begin
               max_d = in_data;
               min_d = in_data;
            end else begin
               if (in_data > max_q) max_d = in_data;
               if (in_data < min_q) min_d = in_data;
            end

            if (gt && gt_cnt_q != C_CNT_MAX) gt_cnt_d = gt_cnt_q + C_CNT_ONE;
            if (eq && eq_cnt_q != C_CNT_MAX) eq_cnt_d = eq_cnt_q + C_CNT_ONE;
            if (sm && sm_cnt_q != C_CNT_MAX) sm_cnt_d = sm_cnt_q + C_CNT_ONE;

            if (gt) begin
               run_d = (run_q == C_RUN_LEN) ? run_q : run_q + 4'd1;
            end else begin
               run_d = 4'd0;
            end

            // Hysteresis: once in ALARM only a strictly-below sample leaves.
            case (state_q)
               S_ALARM: state_d = sm ? S_TRACK : S_ALARM;
               default: state_d = (gt && run_d == C_RUN_LEN) ? S_ALARM : S_TRACK;
            endcase
         end
      end

      alarm_d = (state_d == S_ALARM);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         run_q    <= 4'd0;
         max_q    <= 4'd0;
         min_q    <= 4'd0;
         gt_cnt_q <= '0;
         eq_cnt_q <= '0;
         sm_cnt_q <= '0;
         valid_q  <= 1'b0;
         alarm_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         max_q    <= max_d;
         min_q    <= min_d;
         gt_cnt_q <= gt_cnt_d;
         eq_cnt_q <= eq_cnt_d;
         sm_cnt_q <= sm_cnt_d;
         valid_q  <= valid_d;
         alarm_q  <= alarm_d;
         err_q    <= err_d;
      end
   end

   assign max_val   = max_q;
   assign min_val   = min_q;
   assign gt_cnt    = gt_cnt_q;
   assign eq_cnt    = eq_cnt_q;
   assign sm_cnt    = sm_cnt_q;
   assign alarm     = alarm_q;
   assign out_valid = valid_q;
   assign err       = err_q;

endmodule
`default_nettype wire
